// File: rtl/bpm_readback_collector.sv
// Collects one packet per BPM per fast-acquisition cycle from the merged two-link stream,
// drops duplicates, and publishes positions through a double-buffered table.
module bpm_readback_collector #(
   parameter int NBPM    = 32,
   parameter int TIMEOUT = 10000,
   parameter int DW      = 112
) (
   input  logic            aclk,
   input  logic            areset,
   input  logic            fa_start,
   input  logic            s_tvalid,
   output logic            s_tready,
   input  logic [DW-1:0]   s_tdata,
   input  logic [7:0]      rd_addr,
   output logic [103:0]    rd_data,
   output logic            frame_done,
   output logic            frame_timeout,
   output logic [NBPM-1:0] seen_mask,
   output logic [8:0]      pkt_count,
   output logic [15:0]     dup_count,
   output logic [15:0]     bad_count
);

   localparam int AW    = (NBPM > 1) ? $clog2(NBPM) : 1;
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int PW    = 104;
   localparam int DEPTH = 2 ** AW;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_CLOSE
   } state_t;

   state_t          state;
   logic            wr_bank;
   logic [NBPM-1:0] seen_work;
   logic [8:0]      count_work;
   logic [TW-1:0]   timer;
   logic            to_flag;
   logic            restart;

   logic [7:0]      beat_idx;
   logic [PW-1:0]   beat_payload;
   logic [AW-1:0]   beat_addr;
   logic            accept;
   logic            in_range;
   logic            beat_new;
   logic            complete;
   logic            expire;
   logic            start_collect;
   logic            rd_ok;

   logic [PW-1:0]   mem [2*DEPTH];

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign beat_idx      = s_tdata[111:104];
   assign beat_payload  = s_tdata[PW-1:0];
   assign beat_addr     = beat_idx[AW-1:0];
   assign accept        = s_tvalid & s_tready;
   assign in_range      = ({1'b0, beat_idx} < 9'(NBPM));
   assign beat_new      = (state == ST_COLLECT) && accept && in_range && !seen_work[beat_addr];
   assign complete      = beat_new && ((count_work + 9'd1) == 9'(NBPM));
   assign expire        = (timer == TW'(TIMEOUT - 1));
   assign start_collect = ((state == ST_IDLE) && fa_start) ||
                          ((state == ST_CLOSE) && (restart || fa_start));
   assign rd_ok         = ({1'b0, rd_addr} < 9'(NBPM));

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state         <= ST_IDLE;
         s_tready      <= 1'b0;
         frame_done    <= 1'b0;
         frame_timeout <= 1'b0;
         seen_mask     <= '0;
         pkt_count     <= '0;
         dup_count     <= '0;
         bad_count     <= '0;
         wr_bank       <= 1'b0;
         seen_work     <= '0;
         count_work    <= '0;
         timer         <= '0;
         to_flag       <= 1'b0;
         restart       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               s_tready <= 1'b1;
               if (accept) bad_count <= sat_inc(bad_count);
            end
            ST_COLLECT: begin
               timer <= timer + TW'(1);
               if (accept) begin
                  if (!in_range)                 bad_count <= sat_inc(bad_count);
                  else if (seen_work[beat_addr]) dup_count <= sat_inc(dup_count);
                  else begin
                     seen_work[beat_addr] <= 1'b1;
                     count_work           <= count_work + 9'd1;
                  end
               end
               // Completion outranks both timer expiry and an early restart.
               if (complete) begin
                  state    <= ST_CLOSE;
                  s_tready <= 1'b0;
                  to_flag  <= 1'b0;
               end else if (expire || fa_start) begin
                  state    <= ST_CLOSE;
                  s_tready <= 1'b0;
                  to_flag  <= 1'b1;
               end
               if (fa_start) restart <= 1'b1;
            end
            ST_CLOSE: begin
               wr_bank       <= ~wr_bank;
               seen_mask     <= seen_work;
               pkt_count     <= count_work;
               frame_done    <= 1'b1;
               frame_timeout <= to_flag;
               restart       <= 1'b0;
               state         <= ST_IDLE;
               s_tready      <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
         // NOTE: these assignments come last so they override the per-state updates above;
         // with non-blocking assignments the final one scheduled in the block wins.
         if (start_collect) begin
            state      <= ST_COLLECT;
            s_tready   <= 1'b1;
            seen_work  <= '0;
            count_work <= '0;
            timer      <= '0;
            to_flag    <= 1'b0;
            dup_count  <= '0;
            bad_count  <= '0;
         end
      end
   end

   // NOTE: the table and read register carry no reset; contents are only meaningful
   // once written, and leaving them unreset keeps them mappable to block RAM.
   always_ff @(posedge aclk) begin
      if (beat_new) mem[{wr_bank, beat_addr}] <= beat_payload;
      rd_data <= rd_ok ? mem[{~wr_bank, rd_addr[AW-1:0]}] : '0;
   end

endmodule

// File: doc/bpm_readback_collector.md
Name: bpm_readback_collector

Overview:
Consumer of the 112-bit merged BPM stream produced by the two-link stream mux. Collects one packet per BPM for each fast-acquisition (FA) cycle and discards duplicates, since both ring links deliver the same BPM. Writes positions into a double-buffered table and reports per-cycle completeness and timeout status to the FOFB computation and readout logic.

Parameters:
NBPM, 32, number of BPMs expected per FA cycle (1..256).
TIMEOUT, 10000, aclk cycles after fa_start before an incomplete cycle is closed.
DW, 112, stream data width (fixed packet format).

Ports:
aclk  in  1  sole clock.
areset  in  1  asynchronous, active-high reset.
fa_start  in  1  single-cycle pulse that opens a new collection cycle.
s_tvalid  in  1  stream valid from mux.
s_tready  out  1  stream ready to mux.
s_tdata  in  112  packet: [111:104] bpm index, [103:96] flags, [95:64] X, [63:32] Y, [31:0] sum.
rd_addr  in  8  readout BPM index.
rd_data  out  104  {flags, X, Y, sum} of rd_addr from the completed bank.
frame_done  out  1  single-cycle pulse when a cycle closes.
frame_timeout  out  1  latched with frame_done: 1 if the cycle closed by timeout.
seen_mask  out  NBPM  per-BPM received flags of the last closed cycle.
pkt_count  out  9  packets accepted in the last closed cycle.
dup_count  out  16  duplicates dropped, saturating, cleared at fa_start.
bad_count  out  16  index>=NBPM or IDLE-state packets, saturating, cleared at fa_start.

Behaviour:
- Reset values: s_tready=0, frame_done=0, frame_timeout=0, seen_mask=0, pkt_count=0, dup_count=0, bad_count=0, write bank=0, state IDLE. rd_data holds its previous value after reset and is undefined until the first fa_start.
- FSM:
  - IDLE: s_tready=1. Each accepted beat increments bad_count and is discarded. fa_start -> COLLECT.
  - COLLECT: s_tready=1. A beat is accepted when s_tvalid&s_tready.
    - New index (<NBPM, seen bit clear): write {flags,X,Y,sum} to the write bank, set the seen bit, increment the count.
    - Seen bit already set: increment dup_count; no write.
    - Index >= NBPM: increment bad_count.
    - Count reaches NBPM: next state CLOSE.
    - Timer reaches TIMEOUT-1: next state CLOSE with timeout flag set.
  - CLOSE: one cycle. s_tready=0. Swap banks. Copy the working seen vector to seen_mask and the working count to pkt_count. Pulse frame_done. Set frame_timeout to the timeout flag. Next state IDLE.
- Timer: 0 on entry to COLLECT, +1 per cycle in COLLECT.
- fa_start while in COLLECT (early restart): treated as a timeout close (frame_timeout=1). The new cycle starts in the cycle after CLOSE. The fa_start that caused the close is consumed; no second start is needed.
- fa_start in the CLOSE cycle: latched and applied in the following cycle.
- On entry to COLLECT: working seen vector=0, count=0, timeout flag=0; dup_count and bad_count cleared.
- A beat that completes the count and a timer expiry in the same cycle: completion wins (frame_timeout=0), and the beat is written.
- Table: two banks of NBPM x 104 bits. Writes go to the write bank; reads come from the other bank. rd_data is registered with 1-cycle latency. A bank swap takes effect for reads issued from the cycle after CLOSE.
- Saturating counters stop at 0xFFFF.
- areset asserted mid-cycle: the FSM returns to IDLE immediately. The partial cycle is lost and frame_done is not pulsed.

Test Plan:
1. Reset, then fa_start, then indices 0..31 in order, one per cycle -> frame_done 33 cycles after fa_start; frame_timeout=0; seen_mask=0xFFFFFFFF; pkt_count=32; rd_addr=5 returns the index-5 payload one cycle later.
2. Each index sent twice, interleaved as link A then link B (64 beats) -> pkt_count=32; dup_count=32; table holds the first copy of each index.
3. Indices 0..30 only, TIMEOUT=100 -> frame_done at cycle 100 after entry to COLLECT; frame_timeout=1; seen_mask=0x7FFFFFFF; pkt_count=31.
4. Beats with index 40 and 255 during COLLECT, plus 3 beats while IDLE -> bad_count=2 after the next fa_start cycle. The IDLE beats were counted and then cleared, so a 3 must be observed before fa_start.
5. Second fa_start at cycle 20 of a cycle -> timeout close with frame_timeout=1, followed by a new COLLECT. Bank readout shows cycle-1 data while cycle-2 is being written.
6. areset pulsed after 10 of 32 packets -> s_tready=0 and no frame_done. A subsequent full cycle completes normally with pkt_count=32.
